encoder38_sync: RTL and testbench
=================================

Name: encoder38_sync

Overview:
- Registered 8-to-3 encoder. It is the receive-side counterpart of the 3-to-8 select decoder.
- Takes 8 select/key lines with programmable polarity and synchronises them to the clock, then debounces them.
- Priority-encodes the stable vector into a 3-bit index. Qualifies the result with valid, strobe and multi-hit flags.
- Sits between external select lines (switches, strobes, decoder outputs looped back) and control logic.

Parameters:
- DEB_CYCLES, 16, consecutive clocks the normalised vector must stay unchanged before it is committed. Legal range is 2..65535.
- CNT_W, $clog2(DEB_CYCLES), width of the debounce counter. It is derived and must not be overridden.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_y  input  8  raw select lines; asynchronous to i_clk.
- i_opt  input  1  polarity select. 1 = lines are active-high. 0 = lines are active-low (one-cold, idle 8'hFF).
- o_sel  output  3  encoded index of the lowest-numbered asserted line.
- o_valid  output  1  high while the committed vector has at least one asserted line.
- o_multi  output  1  high while the committed vector has more than one asserted line.
- o_strobe  output  1  one-cycle pulse on each new committed nonzero code.

Behaviour:
- Reset (async, i_rst=1):
  - o_sel=0, o_valid=0, o_multi=0, o_strobe=0.
  - Sync stages = 0, committed vector = 0, debounce counter = 0, state = S_IDLE.
  - Deassertion takes effect at the next rising edge.
- Synchronisation: two flop stages on i_y; i_opt is not synchronised (quasi-static).
- Normalise: n = i_opt ? sync2 : ~sync2, giving an active-high vector.
- Debounce:
  - Register n into n_prev each cycle.
  - If n != n_prev, the counter clears to 0. Otherwise it increments, saturating at DEB_CYCLES-1.
  - When the counter equals DEB_CYCLES-1 and n == n_prev, n is committed to vec_q.
  - The post-reset sync flush and any i_opt change appear as input changes and restart the count.
- Encode: idx = lowest set bit of vec_q (bit 0 has highest priority). multi = popcount(vec_q) > 1.
- FSM, one output-register stage after commit:
  - S_IDLE: if vec_q is nonzero, go to S_ACTIVE. Same cycle: o_sel<=idx, o_valid<=1, o_multi<=multi, o_strobe<=1.
  - S_ACTIVE, vec_q zero: go to S_IDLE. o_valid<=0, o_multi<=0, o_strobe<=0. o_sel holds its last value.
  - S_ACTIVE, vec_q nonzero and idx or multi changed: stay. Update o_sel/o_multi and pulse o_strobe for one cycle.
  - S_ACTIVE, otherwise: hold all outputs, o_strobe=0.
- Latency: from the first edge that samples a new stable i_y to o_strobe high is exactly DEB_CYCLES+3 edges.
- Boundary cases:
  - A glitch shorter than DEB_CYCLES cycles produces no output change.
  - A change to a different nonzero vector goes directly to the new code. There is no forced idle cycle.
  - A new higher-numbered line added while a lower one is held keeps idx unchanged. It sets o_multi and pulses o_strobe.
  - Reset mid-debounce discards the pending count.
  - o_strobe is never high for 2 consecutive cycles.

Decomposition:
- Package encoder38_pkg:
  - State enum {S_IDLE, S_ACTIVE}.
  - Constants NUM_LINES=8, SEL_W=3.
  - Function prio_enc8 (vector to index).
  - Function multi_hot8.
- One sub-module, debounce_vec. Parameters WIDTH and DEB_CYCLES. Ports i_clk, i_rst, i_d, o_q, o_commit. It contains the sync, n_prev and counter logic.
- The top level contains normalisation, encode, FSM and output registers.

Test Plan:
- Reset then idle: i_opt=0, i_y=8'hFF for 100 cycles -> o_valid=0, o_strobe never 1, o_sel=0.
- Single active-low press: i_opt=0, i_y=8'hF7 held 40 cycles -> at edge DEB_CYCLES+3 (19), o_strobe=1 for one cycle; o_sel=3, o_valid=1, o_multi=0. Release to 8'hFF -> o_valid=0 after 19 edges, o_sel stays 3.
- Bounce rejection: i_opt=1, i_y toggles 8'h00/8'h20 every 5 cycles for 60 cycles, then holds 8'h20 -> no strobe during toggling. One strobe 19 edges after the final transition, o_sel=5.
- Multi-hit priority: i_opt=1, hold 8'h04, then add bit 6 (8'h44) -> first strobe with o_sel=2, o_multi=0. Second strobe with o_sel=2, o_multi=1.
- Direct transition: i_opt=1, 8'h01 held, then 8'h80 -> o_sel goes 0 to 7 with o_valid held at 1 throughout and exactly one strobe per code.
- Async reset mid-operation: assert i_rst for 1 cycle between edges while S_ACTIVE with o_sel=7 -> all outputs 0 immediately. With i_y still 8'h80, re-commit and strobe 19 edges after reset release.

Source files
------------

// File: rtl/encoder38_pkg.sv
// Shared types, constants and encode helpers for the 8-to-3 registered encoder.
package encoder38_pkg;

  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned SEL_W     = 3;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  // Index of the lowest set bit; bit 0 has highest priority. Returns 0 for an all-zero vector.
  function automatic logic [SEL_W-1:0] prio_enc8(input logic [NUM_LINES-1:0] v);
    logic [SEL_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (!found && v[i]) begin
        idx   = SEL_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // True when more than one bit is set (clearing the lowest set bit leaves something behind).
  function automatic logic multi_hot8(input logic [NUM_LINES-1:0] v);
    return (v & (v - 8'd1)) != '0;
  endfunction

endpackage

// File: rtl/encoder38_sync_if.sv
// Select-line bus between external lines / control logic and the encoder.
interface encoder38_sync_if;
  import encoder38_pkg::*;

  logic [NUM_LINES-1:0] i_y;
  logic                 i_opt;
  logic [SEL_W-1:0]     o_sel;
  logic                 o_valid;
  logic                 o_multi;
  logic                 o_strobe;

  modport master (
    output i_y,
    output i_opt,
    input  o_sel,
    input  o_valid,
    input  o_multi,
    input  o_strobe
  );

  modport slave (
    input  i_y,
    input  i_opt,
    output o_sel,
    output o_valid,
    output o_multi,
    output o_strobe
  );

endinterface

// File: rtl/debounce_vec.sv
// Two-stage synchroniser followed by a whole-vector debouncer.
// o_q is the committed vector; o_commit pulses for one cycle when o_q takes a new value.
module debounce_vec #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_commit
);

  localparam int unsigned      CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q,  prev_d;
  logic [WIDTH-1:0] vec_q,   vec_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             commit_q, commit_d;
  logic             stable;
  logic             commit;

  // Next-state: synchroniser shift, stability counter and commit decision.
  // The commit test looks at the counter's next value, so the vector is
  // committed on the same edge the count reaches DEB_CYCLES-1.
  always_comb begin
    sync1_d = i_d;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    stable  = (sync2_q == prev_q);

    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    commit   = stable && (cnt_d == CNT_MAX);
    vec_d    = commit ? sync2_q : vec_q;
    commit_d = commit && (sync2_q != vec_q);
  end

  // State registers; reset discards any pending count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      vec_q    <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
    end
  end

  assign o_q      = vec_q;
  assign o_commit = commit_q;

endmodule

// File: rtl/encoder38_sync.sv
// Registered 8-to-3 encoder: polarity normalise, synchronise/debounce, priority
// encode, then a two-state FSM driving registered sel/valid/multi/strobe.
module encoder38_sync
  import encoder38_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input logic              i_clk,
  input logic              i_rst,
  encoder38_sync_if.slave  bus
);

  logic [NUM_LINES-1:0] norm;
  logic [NUM_LINES-1:0] vec;
  logic                 commit;
  logic [SEL_W-1:0]     idx;
  logic                 multi;

  state_t               state_q,  state_d;
  logic [SEL_W-1:0]     sel_q,    sel_d;
  logic                 valid_q,  valid_d;
  logic                 multi_q,  multi_d;
  logic                 strobe_q, strobe_d;

  // Polarity is applied ahead of the synchroniser; i_opt is quasi-static, so
  // an i_opt change still reaches the debouncer as an input change.
  always_comb begin
    norm = bus.i_opt ? bus.i_y : ~bus.i_y;
  end

  debounce_vec #(
    .WIDTH      (NUM_LINES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_d      (norm),
    .o_q      (vec),
    .o_commit (commit)
  );

  // Encode the committed vector.
  always_comb begin
    idx   = prio_enc8(vec);
    multi = multi_hot8(vec);
  end

  // FSM next-state and output values; acts only when a new vector was committed.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    multi_d  = multi_q;
    strobe_d = 1'b0;
    if (commit) begin
      unique case (state_q)
        S_IDLE: begin
          if (vec != '0) begin
            state_d  = S_ACTIVE;
            sel_d    = idx;
            valid_d  = 1'b1;
            multi_d  = multi;
            strobe_d = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (vec == '0) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            multi_d = 1'b0;
          end else if ((idx != sel_q) || (multi != multi_q)) begin
            sel_d    = idx;
            multi_d  = multi;
            strobe_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      multi_q  <= multi_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.o_sel    = sel_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_multi  = multi_q;
  assign bus.o_strobe = strobe_q;

endmodule

// File: tb/tb_encoder38_sync.sv
// Scoreboard bench for encoder38_sync: the driver pushes the expected strobe
// (code, multi flag, edge number) and a negedge monitor pops and compares.
module tb_encoder38_sync;

  localparam int unsigned DEB = 16;
  localparam int unsigned LAT = DEB + 3;

  typedef struct {
    logic [2:0]  sel;
    logic        multi;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic        prev_strobe = 1'b0;
  logic        all_valid;

  encoder38_sync_if bus ();

  encoder38_sync #(.DEB_CYCLES(DEB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: drive new lines and, if a strobe is due, queue it.
  task automatic apply(input logic [7:0] y, input logic opt, input bit expect_strobe,
                       input logic [2:0] sel, input logic multi);
    exp_t e;
    bus.i_y   = y;
    bus.i_opt = opt;
    if (expect_strobe) begin
      e.sel   = sel;
      e.multi = multi;
      e.cyc   = cyc + LAT;
      exp_q.push_back(e);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},    int'(bus.o_sel),    0);
    chk({tag, "_valid"},  int'(bus.o_valid),  0);
    chk({tag, "_multi"},  int'(bus.o_multi),  0);
    chk({tag, "_strobe"}, int'(bus.o_strobe), 0);
  endtask

  // Monitor: every strobe must match the head of the queue, on the expected edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_strobe === 1'b1) begin
      chk("strobe_back_to_back", int'(prev_strobe), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got strobe at edge %0d, expected none (sel=%0d)", cyc, bus.o_sel);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_edge",  int'(cyc),         int'(e.cyc));
        chk("strobe_sel",   int'(bus.o_sel),   int'(e.sel));
        chk("strobe_multi", int'(bus.o_multi), int'(e.multi));
        chk("strobe_valid", int'(bus.o_valid), 1);
      end
    end
    prev_strobe = bus.o_strobe;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at edge %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c;
    rst       = 1'b1;
    bus.i_y   = 8'hFF;
    bus.i_opt = 1'b0;
    step(3);
    chk_all_zero("reset");
    rst = 1'b0;

    // Idle, active-low lines all released.
    step(100);
    chk("idle_valid", int'(bus.o_valid), 0);
    chk("idle_sel",   int'(bus.o_sel),   0);

    // Single active-low press on line 3, then release.
    apply(8'hF7, 1'b0, 1'b1, 3'd3, 1'b0);
    step(40);
    chk("press_valid", int'(bus.o_valid), 1);
    chk("press_sel",   int'(bus.o_sel),   3);
    chk("press_multi", int'(bus.o_multi), 0);
    apply(8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    c = cyc;
    step(LAT - 1);
    chk("release_valid_before", int'(bus.o_valid), 1);
    step(1);
    chk("release_edge", int'(cyc - c), int'(LAT));
    chk("release_valid_after", int'(bus.o_valid), 0);
    chk("release_sel_hold",    int'(bus.o_sel),   3);
    step(10);

    // Bounce: 5-cycle toggles are rejected; the final stable level commits.
    apply(8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    step(5);
    for (int s = 0; s < 12; s++) begin
      apply((s % 2 == 0) ? 8'h20 : 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
      step(5);
    end
    apply(8'h20, 1'b1, 1'b1, 3'd5, 1'b0);
    step(40);
    chk("bounce_sel", int'(bus.o_sel), 5);

    // Multi-hit: line 2, then add line 6 (index unchanged, multi set).
    apply(8'h04, 1'b1, 1'b1, 3'd2, 1'b0);
    step(40);
    apply(8'h44, 1'b1, 1'b1, 3'd2, 1'b1);
    step(40);
    chk("multi_flag", int'(bus.o_multi), 1);

    // Direct transitions between nonzero codes; valid never drops.
    apply(8'h01, 1'b1, 1'b1, 3'd0, 1'b0);
    step(40);
    apply(8'h80, 1'b1, 1'b1, 3'd7, 1'b0);
    all_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step(1);
      all_valid = all_valid & bus.o_valid;
    end
    chk("direct_valid_held", int'(all_valid), 1);
    chk("direct_sel",        int'(bus.o_sel), 7);

    // Async reset between edges while active on line 7.
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    apply(8'h80, 1'b1, 1'b1, 3'd7, 1'b0);
    step(40);

    // Reset in the middle of a debounce restarts the count from release.
    apply(8'h02, 1'b1, 1'b0, 3'd0, 1'b0);
    step(8);
    #2 rst = 1'b1;
    #1 chk("middeb_valid", int'(bus.o_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(8'h02, 1'b1, 1'b1, 3'd1, 1'b0);
    step(40);
    chk("middeb_sel", int'(bus.o_sel), 1);

    step(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
